password_entry: RTL

//  Upstream stage of the access-control block: collects four 4-bit digits keyed on switches,
//  one per Enter press, and packs them MSB-first into a 16-bit word. On the 4th digit it presents
//  {mode, word} on _Data_Out and pulses _Data_Out_Load one cycle, driving the access-control

---
 rtl/access_pkg.sv | 23 ++
 rtl/rise_edge_detect.sv | 31 +++
 rtl/password_entry.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/access_pkg.sv
// Shared types for the password entry and access-control stages.
// Widths, state encoding and the word-packing helper live here.
package access_pkg;

    localparam int DIGIT_W = 4;
    localparam int PW_W    = 16;
    localparam int DATA_W  = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOAD    = 2'd2
    } entry_state_e;

    // Mode bit sits above the packed password word.
    function automatic logic [DATA_W-1:0] pack_entry(
        input logic            mode,
        input logic [PW_W-1:0] word
    );
        return {mode, word};
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Registered rising-edge detector with a configurable reset level.
// A reset level of 1 suppresses a press for an input held through reset.
module rise_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic sig_d;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        sig_d = sig_i;
    end

    // Delay register, forced to RST_VAL while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/password_entry.sv
// Collects four keyed digits and emits {mode, word} with a one-cycle load.
// Optional inactivity abort is enabled by defining ENTRY_TIMEOUT_EN.
import access_pkg::*;

module password_entry #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] _Digit_In,
    input  logic               _Enter,
    input  logic               _Clear,
    input  logic               _Mode,
    output logic [DATA_W-1:0]  _Data_Out,
    output logic               _Data_Out_Load,
    output logic [2:0]         _Digit_Count,
    output logic               _Busy,
    output logic               _Timeout
);

    localparam int          PRE_W    = PW_W - DIGIT_W;
    localparam logic [2:0]  LAST_CNT = 3'(NUM_DIGITS - 1);

    entry_state_e      state_q, state_d;
    logic [2:0]        count_q, count_d;
    logic [PRE_W-1:0]  prefix_q, prefix_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              press;

    rise_edge_detect #(
        .RST_VAL (1'b1)
    ) u_enter_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (_Enter),
        .rise_o (press)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Next-state logic: Clear beats any press; LOAD always completes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        prefix_d   = prefix_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
`ifdef ENTRY_TIMEOUT_EN
        timer_d    = timer_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (_Clear) begin
                    count_d  = 3'd0;
                    prefix_d = '0;
                end else if (press) begin
                    state_d  = COLLECT;
                    count_d  = 3'd1;
                    prefix_d = PRE_W'(_Digit_In);
                    mode_d   = _Mode;
`ifdef ENTRY_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end
            end
            COLLECT: begin
                if (_Clear) begin
                    state_d  = IDLE;
                    count_d  = 3'd0;
                    prefix_d = '0;
`ifdef ENTRY_TIMEOUT_EN
                    timer_d  = '0;
`endif
                end else if (press) begin
                    count_d  = count_q + 3'd1;
                    prefix_d = {prefix_q[PRE_W-DIGIT_W-1:0], _Digit_In};
`ifdef ENTRY_TIMEOUT_EN
                    timer_d  = '0;
`endif
                    if (count_q == LAST_CNT) begin
                        state_d    = LOAD;
                        data_out_d = pack_entry(mode_q, {prefix_q, _Digit_In});
                    end
                end else begin
`ifdef ENTRY_TIMEOUT_EN
                    if (timer_q == TIMER_LAST) begin
                        state_d   = IDLE;
                        count_d   = 3'd0;
                        prefix_d  = '0;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
            end
            LOAD: begin
                state_d  = IDLE;
                count_d  = 3'd0;
                prefix_d = '0;
            end
            default: begin
                state_d  = IDLE;
                count_d  = 3'd0;
                prefix_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            prefix_q   <= '0;
            mode_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            prefix_q   <= prefix_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    // Inactivity timer, only meaningful while collecting.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign _Timeout = timeout_d;
`else
    assign _Timeout = 1'b0;
`endif

    assign _Data_Out      = data_out_q;
    assign _Data_Out_Load = (state_q == LOAD);
    assign _Digit_Count   = count_q;
    assign _Busy          = (state_q != IDLE);

endmodule
